// File: rtl/sa_operand_feeder.sv
// Operand sequencer feeding a systolic array: holds 3x3 matrices A and B and
// streams column k of A with row k of B as packed beats, then waits out drain.
module sa_operand_feeder #(
    parameter int DATA_W    = 8,
    parameter int N         = 3,
    parameter int DRAIN_CYC = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic                  i_wr_sel,
    input  logic [3:0]            i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_start,
    output logic [N*DATA_W-1:0]   o_A,
    output logic [N*DATA_W-1:0]   o_B,
    output logic                  o_push,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NE   = N * N;
    localparam int K_W  = (N > 1) ? $clog2(N) : 1;
    localparam int DC_W = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [K_W-1:0]        k_q;
    logic [DC_W-1:0]       drain_q;
    logic [N*DATA_W-1:0]   a_out_q;
    logic [N*DATA_W-1:0]   b_out_q;
    logic                  push_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DATA_W-1:0]     a_q [NE];
    logic [DATA_W-1:0]     b_q [NE];

    logic [N*DATA_W-1:0]   beat_a_d;
    logic [N*DATA_W-1:0]   beat_b_d;
    logic                  wr_ok;

    // Storage only changes in IDLE, so a running sequence always sees a stable snapshot.
    assign wr_ok = i_wr_en && (state_q == S_IDLE) && (i_wr_addr < 4'(NE));

    // NOTE: the operand arrays are small register files, so they are cleared on
    // reset like any other state; a RAM macro could not be reset this way.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q <= '{default: '0};
            b_q <= '{default: '0};
        end else if (wr_ok) begin
            if (i_wr_sel) begin
                b_q[i_wr_addr] <= i_wr_data;
            end else begin
                a_q[i_wr_addr] <= i_wr_data;
            end
        end
    end

    // Beat k: lane i of A carries A[i][k], lane j of B carries B[k][j].
    always_comb begin
        beat_a_d = '0;
        beat_b_d = '0;
        for (int i = 0; i < N; i++) begin
            beat_a_d[i*DATA_W +: DATA_W] = a_q[4'(i * N) + 4'(k_q)];
            beat_b_d[i*DATA_W +: DATA_W] = b_q[4'(k_q) * 4'(N) + 4'(i)];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            drain_q <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
            push_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Beat data defaults to zero so nothing stale shows between pushes.
            push_q  <= 1'b0;
            done_q  <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_STREAM;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_STREAM: begin
                    push_q  <= 1'b1;
                    a_out_q <= beat_a_d;
                    b_out_q <= beat_b_d;
                    if (k_q == K_W'(N - 1)) begin
                        k_q     <= '0;
                        drain_q <= '0;
                        state_q <= S_DRAIN;
                    end else begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DC_W'(DRAIN_CYC - 1)) begin
                        drain_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= drain_q + DC_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_A    = a_out_q;
    assign o_B    = b_out_q;
    assign o_push = push_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Directed bench for sa_operand_feeder: loads operands, streams them and checks
// beat contents and per-cycle push/busy/done timing against hand-computed values.
module tb_sa_operand_feeder;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        wr_en   = 1'b0;
    logic        wr_sel  = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start   = 1'b0;
    logic [23:0] o_a;
    logic [23:0] o_b;
    logic        o_push;
    logic        o_busy;
    logic        o_done;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    sa_operand_feeder dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_sel  (wr_sel),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_start   (start),
        .o_A       (o_a),
        .o_B       (o_b),
        .o_push    (o_push),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_el(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Pulses start (cycle T) and checks cycles T+1..T+13. ea/eb hold beats 0..2,
    // beat k in bits [24k+23:24k].
    task automatic run_seq(input string tag, input logic [71:0] ea, input logic [71:0] eb,
                           input bit meddle, input bit same_wr);
        bit exp_push;
        int k;
        start = 1'b1;
        if (same_wr) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b1;
            wr_addr = 4'd0;
            wr_data = 8'h5A;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            exp_push = (c >= 2) && (c <= 4);
            k        = exp_push ? c - 2 : 0;
            check($sformatf("%s c%0d push", tag, c), 32'(o_push), 32'(exp_push));
            check($sformatf("%s c%0d busy", tag, c), 32'(o_busy), 32'((c >= 1) && (c <= 11)));
            check($sformatf("%s c%0d done", tag, c), 32'(o_done), 32'(c == 11));
            check($sformatf("%s c%0d A", tag, c), 32'(o_a), exp_push ? 32'(ea[24*k +: 24]) : 32'd0);
            check($sformatf("%s c%0d B", tag, c), 32'(o_b), exp_push ? 32'(eb[24*k +: 24]) : 32'd0);
            if (meddle && c == 2) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 4'd0;
                wr_data = 8'hFF;
                start   = 1'b1;
            end else if (meddle && c == 11) begin
                start = 1'b1;
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst push", 32'(o_push), 32'd0);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst done", 32'(o_done), 32'd0);
        check("rst A", 32'(o_a), 32'd0);
        check("rst B", 32'(o_b), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // A[r][c] = 10r+c, B[r][c] = 0x80+10r+c
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                write_el(1'b0, 4'(r*3 + c), 8'(10*r + c));
                write_el(1'b1, 4'(r*3 + c), 8'(8'h80 + 10*r + c));
            end
        end

        run_seq("basic", {24'h160C02, 24'h150B01, 24'h140A00},
                         {24'h969594, 24'h8C8B8A, 24'h828180}, 1'b0, 1'b0);
        run_seq("busy_prot", {24'h160C02, 24'h150B01, 24'h140A00},
                             {24'h969594, 24'h8C8B8A, 24'h828180}, 1'b1, 1'b0);
        run_seq("replay", {24'h160C02, 24'h150B01, 24'h140A00},
                          {24'h969594, 24'h8C8B8A, 24'h828180}, 1'b0, 1'b0);

        write_el(1'b0, 4'd9,  8'hEE);
        write_el(1'b0, 4'd15, 8'hDD);
        write_el(1'b0, 4'd8,  8'h11);
        write_el(1'b0, 4'd8,  8'h22);
        run_seq("bound", {24'h220C02, 24'h150B01, 24'h140A00},
                         {24'h969594, 24'h8C8B8A, 24'h828180}, 1'b0, 1'b0);

        run_seq("same_wr", {24'h220C02, 24'h150B01, 24'h140A00},
                           {24'h969594, 24'h8C8B8A, 24'h82815A}, 1'b0, 1'b1);

        // Abort mid-beat: reset lands between clock edges while beat 0 is out.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort pre push", 32'(o_push), 32'd1);
        check("abort pre A", 32'(o_a), 32'h140A00);
        #2 rst_n = 1'b0;
        #1;
        check("abort push", 32'(o_push), 32'd0);
        check("abort A", 32'(o_a), 32'd0);
        check("abort B", 32'(o_b), 32'd0);
        check("abort busy", 32'(o_busy), 32'd0);
        check("abort done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post idle busy", 32'(o_busy), 32'd0);
        check("post idle push", 32'(o_push), 32'd0);
        run_seq("post_rst", 72'd0, 72'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no end of run, expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
